fetch_npc: RTL and testbench

Fetch-stage next-PC generator for the pipelined CPU. Holds the fetch PC, looks it up in a direct-mapped branch target buffer (BTB), and combines the hit with the direction bit from the two-bit saturating-counter predictor to choose the next PC. It also consumes branch resolutions from execute, raising a redirect on mispredict and driving the predictor's training strobe.

---
 rtl/fetch_npc_pkg.sv | 18 +
 rtl/fetch_npc_btb.sv | 84 ++++++++
 rtl/fetch_npc.sv | 129 ++++++++++++
 tb/tb_fetch_npc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_npc_pkg.sv
// fetch_npc_pkg
//   Shared definitions for the fetch next-PC block and its BTB:
//   - pred_state_e : two-bit saturating predictor counter encodings
//   - INST_BYTES   : fetch step, in bytes
//   - RESET_PC_DEFAULT : default fetch PC after reset
package fetch_npc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_state_e;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_npc_btb.sv
// btb_array
//   Direct-mapped branch target buffer.
//   index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2]; each entry holds
//   valid, tag and target.
// Ports:
//   clk_i, rst_n        clock; synchronous active-low clear of valid bits
//   rd_pc_i             lookup PC (asynchronous read)
//   rd_hit_o            entry valid and tag equal
//   rd_target_o         stored target on a hit, 0 on a miss
//   wr_en_i             perform a write/invalidate on this edge
//   wr_set_i            1: write tag+target and set valid; 0: clear valid
//   wr_pc_i             PC selecting index and tag of the write
//   wr_target_i         target to store
module btb_array
  import fetch_npc_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [PC_W-1:0] rd_pc_i,
  output logic            rd_hit_o,
  output logic [PC_W-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic            wr_set_i,
  input  logic [PC_W-1:0] wr_pc_i,
  input  logic [PC_W-1:0] wr_target_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  // Instruction-aligned PCs: the two byte-offset bits take no part in lookup.
  logic unused_lsbs;
  assign unused_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_idx = rd_pc_i[IDX_W+1:2];
  assign rd_tag = rd_pc_i[PC_W-1:IDX_W+2];
  assign wr_idx = wr_pc_i[IDX_W+1:2];
  assign wr_tag = wr_pc_i[PC_W-1:IDX_W+2];

  // Lookup sees the registered contents, so a write in the same cycle is
  // visible only from the next cycle.
  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target_o = rd_hit_o ? target_q[rd_idx] : '0;

  // NOTE: every variable gets its default at the top of always_comb so no
  // path leaves it unassigned (which would infer a latch); combinational
  // blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en_i) begin
      valid_d[wr_idx] = wr_set_i;
      if (wr_set_i) begin
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target_i;
      end
    end
    if (!rst_n) begin
      valid_d = '0;
    end
  end

  // NOTE: only the valid bits are reset; tag and target are storage that is
  // never observed while its valid bit is clear, so it needs no reset.
  always_ff @(posedge clk_i) begin
    valid_q  <= valid_d;
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/fetch_npc.sv
// fetch_npc
//   Fetch-stage next-PC generator. Holds the fetch PC, looks it up in the
//   BTB, combines a hit with the predictor's direction bit, and handles
//   branch resolutions from execute (redirect on mispredict, BTB update,
//   registered predictor training strobe).
// Configuration macro: BPU_BTB_EN
//   defined   : btb_array instantiated
//   undefined : no BTB storage, static not-taken prediction
// Ports:
//   clk_i, rst_n                synchronous active-low reset
//   stall_i                     hold fetch PC
//   predict_i                   predictor direction (1 = taken)
//   pc_o                        current fetch PC
//   pred_taken_o, pred_target_o prediction for pc_o
//   ex_valid_i .. ex_pred_target_i  resolved instruction from execute
//   redirect_o, redirect_pc_o   mispredict flush and corrected PC
//   train_valid_o, train_taken_o    registered predictor training
module fetch_npc
  import fetch_npc_pkg::*;
#(
  parameter int              ENTRIES  = 16,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            predict_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [PC_W-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [PC_W-1:0] ex_pred_target_i,
  output logic            redirect_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            train_valid_o,
  output logic            train_taken_o
);

  localparam logic [PC_W-1:0] STEP = PC_W'(INST_BYTES);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            train_valid_q, train_valid_d;
  logic            train_taken_q, train_taken_d;

  logic            btb_hit;
  logic [PC_W-1:0] btb_target;
  logic            dir_miss, tgt_miss, alias_miss;

`ifdef BPU_BTB_EN
  logic btb_wr_en;

  // Taken branches allocate; a non-branch that was predicted taken aliased
  // onto someone else's entry, so that entry is dropped.
  assign btb_wr_en = ex_valid_i &&
                     ((ex_is_branch_i && ex_taken_i) ||
                      (!ex_is_branch_i && ex_pred_taken_i));

  btb_array #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .rd_pc_i     (pc_q),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .wr_en_i     (btb_wr_en),
    .wr_set_i    (ex_is_branch_i),
    .wr_pc_i     (ex_pc_i),
    .wr_target_i (ex_target_i)
  );
`else
  // Static not-taken: every taken branch resolves as a mispredict.
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  assign pc_o          = pc_q;
  assign pred_taken_o  = rst_n && btb_hit && predict_i;
  assign pred_target_o = btb_target;

  assign dir_miss   = ex_is_branch_i && (ex_taken_i != ex_pred_taken_i);
  assign tgt_miss   = ex_is_branch_i && ex_taken_i && ex_pred_taken_i &&
                      (ex_target_i != ex_pred_target_i);
  assign alias_miss = !ex_is_branch_i && ex_pred_taken_i;

  assign redirect_o = rst_n && ex_valid_i && (dir_miss || tgt_miss || alias_miss);

  always_comb begin
    redirect_pc_o = '0;
    if (redirect_o) begin
      redirect_pc_o = (ex_taken_i && ex_is_branch_i) ? ex_target_i : ex_pc_i + STEP;
    end
  end

  // Lowest priority first; later assignments override.
  always_comb begin
    pc_d = pc_q + STEP;
    if (pred_taken_o) pc_d = pred_target_o;
    if (stall_i)      pc_d = pc_q;
    if (redirect_o)   pc_d = redirect_pc_o;
    if (!rst_n)       pc_d = RESET_PC;
  end

  always_comb begin
    train_valid_d = 1'b0;
    train_taken_d = 1'b0;
    if (rst_n) begin
      train_valid_d = ex_valid_i && ex_is_branch_i;
      train_taken_d = ex_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q          <= pc_d;
    train_valid_q <= train_valid_d;
    train_taken_q <= train_taken_d;
  end

  assign train_valid_o = train_valid_q;
  assign train_taken_o = train_taken_q;

endmodule

// File: tb/tb_fetch_npc.sv
// tb_fetch_npc
//   Self-checking bench for fetch_npc: directed reset/redirect/BTB
//   sequences, a table of resolution vectors, and randomized traffic
//   against a behavioural model. Builds with or without BPU_BTB_EN.
module tb_fetch_npc;

  localparam int ENTRIES = 16;
  localparam int PC_W    = 32;
`ifdef BPU_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n, stall_i, predict_i;
  logic        ex_valid_i, ex_is_branch_i, ex_taken_i, ex_pred_taken_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
  logic [31:0] pc_o, pred_target_o, redirect_pc_o;
  logic        pred_taken_o, redirect_o, train_valid_o, train_taken_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_npc #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .predict_i        (predict_i),
    .pc_o             (pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_pc_i          (ex_pc_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o),
    .train_valid_o    (train_valid_o),
    .train_taken_o    (train_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ex(input bit v, input bit br, input logic [31:0] pc, input bit tk,
                    input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    ex_valid_i       = v;
    ex_is_branch_i   = br;
    ex_pc_i          = pc;
    ex_taken_i       = tk;
    ex_target_i      = tgt;
    ex_pred_taken_i  = ptk;
    ex_pred_target_i = ptgt;
  endtask

  task automatic ex_idle();
    ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Steer fetch to 'a' with a mispredicted taken branch at 0x100 (BTB index 0).
  task automatic goto(input logic [31:0] a, input bit st);
    ex(1'b1, 1'b1, 32'h100, 1'b1, a, 1'b0, 32'h0);
    stall_i = st;
    tick();
    ex_idle();
    stall_i = 1'b0;
  endtask

  // Resolution vectors: redirect decision and corrected PC.
  typedef struct {
    bit          br, tk, ptk;
    logic [31:0] pc, tgt, ptgt;
    bit          exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs[9];

  // Behavioural model: direct-mapped slot = (pc / 4) mod ENTRIES; an entry
  // hits when the stored word address equals the fetch word address.
  bit          m_v   [ENTRIES];
  logic [31:0] m_bpc [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  logic [31:0] m_pc;
  bit          m_tv, m_tt;

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
  endfunction

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; predict_i = 1'b0;
    ex_idle();
    repeat (2) tick();

    // Reset state and sequential fetch with an empty BTB.
    rst_n = 1'b1; predict_i = 1'b1;
    #1;
    check("reset_pc", pc_o, 32'h0);
    check("reset_train_valid", 32'(train_valid_o), 0);
    check("reset_train_taken", 32'(train_taken_o), 0);
    check("reset_redirect", 32'(redirect_o), 0);
    check("empty_pred_taken0", 32'(pred_taken_o), 0);
    tick();
    check("seq_pc4", pc_o, 32'h4);
    check("empty_pred_taken4", 32'(pred_taken_o), 0);
    tick();
    check("seq_pc8", pc_o, 32'h8);
    check("empty_pred_taken8", 32'(pred_taken_o), 0);

    // Taken branch at 0x10 predicted not taken.
    ex(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    check("br_redirect", 32'(redirect_o), 1);
    check("br_redirect_pc", redirect_pc_o, 32'h40);
    tick();
    ex_idle();
    check("br_next_pc", pc_o, 32'h40);
    check("br_train_valid", 32'(train_valid_o), 1);
    check("br_train_taken", 32'(train_taken_o), 1);

    // Fetch of 0x10 with predict_i = 1, then with predict_i = 0.
    goto(32'h10, 1'b0);
    predict_i = 1'b1;
    #1;
    check("hit_pc", pc_o, 32'h10);
    check("hit_pred_taken", 32'(pred_taken_o), 32'(BTB_EN));
    check("hit_pred_target", pred_target_o, BTB_EN ? 32'h40 : 32'h0);
    tick();
    check("hit_next_pc", pc_o, BTB_EN ? 32'h40 : 32'h14);
    goto(32'h10, 1'b0);
    predict_i = 1'b0;
    tick();
    check("nt_pred_next_pc", pc_o, 32'h14);

    // 0x10 resolves not taken after a taken prediction.
    ex(1'b1, 1'b1, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    check("nt_redirect", 32'(redirect_o), 1);
    check("nt_redirect_pc", redirect_pc_o, 32'h14);
    tick();
    ex_idle();
    check("nt_next_pc", pc_o, 32'h14);

    // Redirect together with stall: redirect wins. Entry still valid.
    goto(32'h10, 1'b1);
    check("stall_redirect_pc", pc_o, 32'h10);
    predict_i = 1'b1;
    #1;
    check("entry_kept", 32'(pred_taken_o), 32'(BTB_EN));

    // Non-branch alias at 0x10 invalidates the entry.
    ex(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    check("alias_redirect", 32'(redirect_o), 1);
    check("alias_redirect_pc", redirect_pc_o, 32'h14);
    tick();
    ex_idle();
    check("alias_next_pc", pc_o, 32'h14);
    goto(32'h10, 1'b0);
    #1;
    check("alias_miss", 32'(pred_taken_o), 0);
    check("alias_miss_target", pred_target_o, 32'h0);

    // Repopulate 0x10, then reset in the middle of a redirect.
    ex(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, BTB_EN, BTB_EN ? 32'h40 : 32'h0);
    tick();
    rst_n = 1'b0;
    stall_i = 1'b1;
    ex(1'b1, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    check("rst_redirect_low", 32'(redirect_o), 0);
    check("rst_pred_taken_low", 32'(pred_taken_o), 0);
    tick();
    rst_n = 1'b1;
    stall_i = 1'b0;
    ex_idle();
    check("rst_mid_pc", pc_o, 32'h0);
    check("rst_mid_train_valid", 32'(train_valid_o), 0);
    check("rst_mid_train_taken", 32'(train_taken_o), 0);
    goto(32'h10, 1'b0);
    predict_i = 1'b1;
    #1;
    check("rst_btb_miss", 32'(pred_taken_o), 0);

    // Resolution table.
    vecs[0] = '{1, 1, 1, 32'h50, 32'h200, 32'h200, 0, 32'h0};
    vecs[1] = '{1, 1, 1, 32'h50, 32'h200, 32'h204, 1, 32'h200};
    vecs[2] = '{1, 0, 0, 32'h50, 32'h200, 32'h0,   0, 32'h0};
    vecs[3] = '{1, 0, 1, 32'h50, 32'h200, 32'h200, 1, 32'h54};
    vecs[4] = '{1, 1, 0, 32'h50, 32'h300, 32'h0,   1, 32'h300};
    vecs[5] = '{0, 0, 1, 32'h60, 32'h0,   32'h80,  1, 32'h64};
    vecs[6] = '{0, 0, 0, 32'h60, 32'h0,   32'h0,   0, 32'h0};
    vecs[7] = '{0, 1, 1, 32'hFFFF_FFFC, 32'h44, 32'h44, 1, 32'h0};
    vecs[8] = '{1, 0, 1, 32'hFFFF_FFFC, 32'h44, 32'h44, 1, 32'h0};
    stall_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ex(1'b1, vecs[i].br, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      check($sformatf("vec%0d_redirect", i), 32'(redirect_o), 32'(vecs[i].exp_redir));
      check($sformatf("vec%0d_redirect_pc", i), redirect_pc_o, vecs[i].exp_rpc);
      ex_valid_i = 1'b0;
      #1;
      check($sformatf("vec%0d_idle", i), 32'(redirect_o), 0);
      tick();
    end
    ex_idle();
    stall_i = 1'b0;

    // Randomized traffic against the model.
    rst_n = 1'b0;
    tick();
    m_pc = 32'h0;
    m_tv = 1'b0;
    m_tt = 1'b0;
    for (int s = 0; s < ENTRIES; s++) m_v[s] = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      int          fs, ws;
      bit          hit, ptk, mis;
      logic [31:0] ptgt, rpc;

      rst_n            = ($urandom_range(0, 99) != 0);
      stall_i          = ($urandom_range(0, 3) == 0);
      predict_i        = 1'($urandom_range(0, 1));
      ex_valid_i       = 1'($urandom_range(0, 1));
      ex_is_branch_i   = ($urandom_range(0, 3) != 0);
      ex_pc_i          = rand_pc();
      ex_taken_i       = 1'($urandom_range(0, 1));
      ex_target_i      = rand_pc();
      ex_pred_taken_i  = 1'($urandom_range(0, 1));
      ex_pred_target_i = ($urandom_range(0, 1) != 0) ? ex_target_i : rand_pc();
      #1;

      fs   = int'((m_pc >> 2) % ENTRIES);
      hit  = BTB_EN && m_v[fs] && (m_bpc[fs][31:2] == m_pc[31:2]);
      ptk  = rst_n && hit && predict_i;
      ptgt = hit ? m_tgt[fs] : 32'h0;
      mis  = rst_n && ex_valid_i &&
             ((ex_is_branch_i && ex_taken_i != ex_pred_taken_i) ||
              (ex_is_branch_i && ex_taken_i && ex_pred_taken_i &&
               ex_target_i != ex_pred_target_i) ||
              (!ex_is_branch_i && ex_pred_taken_i));
      rpc  = !mis ? 32'h0 : (ex_is_branch_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;

      check("rnd_pc", pc_o, m_pc);
      check("rnd_pred_taken", 32'(pred_taken_o), 32'(ptk));
      check("rnd_pred_target", pred_target_o, ptgt);
      check("rnd_redirect", 32'(redirect_o), 32'(mis));
      check("rnd_redirect_pc", redirect_pc_o, rpc);
      check("rnd_train_valid", 32'(train_valid_o), 32'(m_tv));
      check("rnd_train_taken", 32'(train_taken_o), 32'(m_tt));

      if (!rst_n) begin
        m_pc = 32'h0;
        m_tv = 1'b0;
        m_tt = 1'b0;
        for (int s = 0; s < ENTRIES; s++) m_v[s] = 1'b0;
      end else begin
        if (mis)          m_pc = rpc;
        else if (stall_i) m_pc = m_pc;
        else if (ptk)     m_pc = ptgt;
        else              m_pc = m_pc + 32'd4;
        ws = int'((ex_pc_i >> 2) % ENTRIES);
        if (ex_valid_i && ex_is_branch_i && ex_taken_i) begin
          m_v[ws]   = 1'b1;
          m_bpc[ws] = ex_pc_i;
          m_tgt[ws] = ex_target_i;
        end else if (ex_valid_i && !ex_is_branch_i && ex_pred_taken_i) begin
          m_v[ws] = 1'b0;
        end
        m_tv = ex_valid_i && ex_is_branch_i;
        m_tt = ex_taken_i;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
